// File: rtl/aclk_keypad_scanner.sv
// Alarm-clock 4x3 keypad scanner: column drive, 2-flop row sync, frame decode, debounce FSM.
// Optional macro ACLK_KEY_GHOST_REJECT_EN: frames with two or more digits pressed decode as NO_KEY.
module aclk_keypad_scanner #(
    parameter int         SCAN_DIV        = 256,
    parameter int         DEBOUNCE_FRAMES = 4,
    parameter logic [3:0] NO_KEY          = 4'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_pulse
);

    localparam int               DIV_W        = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_TARGET   = 4'(DEBOUNCE_FRAMES);
    localparam bit               SINGLE_FRAME = (DEBOUNCE_FRAMES == 1);
`ifdef ACLK_KEY_GHOST_REJECT_EN
    localparam bit               GHOST_REJECT = 1'b1;
`else
    localparam bit               GHOST_REJECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [2:0]       col_n_q, col_n_d;
    logic [11:0]      frame_q, frame_d, frame_now;
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d, cnt_inc;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_pulse_q, key_pulse_d;
    logic             tc, frame_end;
    logic [3:0]       result;
    logic [3:0]       hit_count;
    logic [3:0]       pressed;

    // Scan index is row-major (row*3 + col); '*' and '#' decode as NO_KEY.
    function automatic logic [3:0] key_code(input int idx);
        if (idx <= 8)
            return 4'(idx + 1);
        else if (idx == 10)
            return 4'd0;
        else
            return NO_KEY;
    endfunction

    // Column stepping and per-frame accumulation of pressed switches.
    always_comb begin
        tc        = (div_q == DIV_LAST);
        frame_end = tc && (col_idx_q == 2'd2);
        div_d     = tc ? '0 : div_q + 1'b1;
        col_idx_d = col_idx_q;
        col_n_d   = col_n_q;
        pressed   = ~row_sync_q;
        frame_now = frame_q;

        unique case (col_idx_q)
            2'd0: for (int r = 0; r < 4; r++) frame_now[r*3]     = pressed[r];
            2'd1: for (int r = 0; r < 4; r++) frame_now[r*3 + 1] = pressed[r];
            default: for (int r = 0; r < 4; r++) frame_now[r*3 + 2] = pressed[r];
        endcase

        frame_d = frame_q;
        if (tc) begin
            if (col_idx_q == 2'd2) begin
                col_idx_d = 2'd0;
                col_n_d   = 3'b110;
                frame_d   = '0;
            end else begin
                col_idx_d = col_idx_q + 2'd1;
                col_n_d   = {col_n_q[1:0], col_n_q[2]};
                frame_d   = frame_now;
            end
        end
    end

    // Descending loop so the lowest scan index is the one left in result.
    always_comb begin
        result    = NO_KEY;
        hit_count = '0;
        for (int i = 11; i >= 0; i--) begin
            if (frame_now[i] && (key_code(i) != NO_KEY)) begin
                result    = key_code(i);
                hit_count = hit_count + 4'd1;
            end
        end
        if (GHOST_REJECT && (hit_count > 4'd1))
            result = NO_KEY;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        key_pulse_d = 1'b0;
        cnt_inc     = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

        if (frame_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (result != NO_KEY) begin
                        cand_d = result;
                        cnt_d  = 4'd1;
                        if (SINGLE_FRAME) begin
                            state_d     = ST_PRESSED;
                            key_d       = result;
                            key_valid_d = 1'b1;
                            key_pulse_d = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (result == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_TARGET) begin
                            state_d     = ST_PRESSED;
                            key_d       = cand_q;
                            key_valid_d = 1'b1;
                            key_pulse_d = 1'b1;
                        end
                    end else if (result == NO_KEY) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cand_d = result;
                        cnt_d  = 4'd1;
                    end
                end
                ST_PRESSED: begin
                    if (result != cand_q) begin
                        cnt_d = 4'd1;
                        if (SINGLE_FRAME) begin
                            state_d     = ST_IDLE;
                            key_d       = NO_KEY;
                            key_valid_d = 1'b0;
                            cnt_d       = 4'd0;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (result == cand_q) begin
                        state_d = ST_PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_TARGET) begin
                            state_d     = ST_IDLE;
                            key_d       = NO_KEY;
                            key_valid_d = 1'b0;
                            cnt_d       = 4'd0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous so outputs clear immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            col_n_q     <= 3'b110;
            frame_q     <= '0;
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_q       <= NO_KEY;
            key_valid_q <= 1'b0;
            key_pulse_q <= 1'b0;
        end else begin
            row_meta_q  <= row_n;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            frame_q     <= frame_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    assign col_n     = col_n_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Bench for aclk_keypad_scanner: keypad switch model, frame-level debounce reference, directed and random holds.
// Honours ACLK_KEY_GHOST_REJECT_EN in its reference model.
module tb_aclk_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DF       = 3;
    localparam int FRAME    = 3 * SCAN_DIV;
    localparam int NO_KEY   = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [2:0]  col_n;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_pulse;
    logic [11:0] held = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int key_m, run_digit, run_len, miss;

    always #5 clk = ~clk;

    // Switch matrix: a held switch pulls its row low while its column is driven.
    assign row_n[0] = ~|(held[2:0]  & ~col_n);
    assign row_n[1] = ~|(held[5:3]  & ~col_n);
    assign row_n[2] = ~|(held[8:6]  & ~col_n);
    assign row_n[3] = ~|(held[11:9] & ~col_n);

    aclk_keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DF),
        .NO_KEY         (4'd10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_n    (row_n),
        .col_n    (col_n),
        .key      (key),
        .key_valid(key_valid),
        .key_pulse(key_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int frame_result(input logic [11:0] h);
        int keymap [12];
        int found;
        int n;
        keymap = '{1, 2, 3, 4, 5, 6, 7, 8, 9, NO_KEY, 0, NO_KEY};
        found  = NO_KEY;
        n      = 0;
        for (int i = 0; i < 12; i++) begin
            if (h[i] && keymap[i] != NO_KEY) begin
                n++;
                if (found == NO_KEY) found = keymap[i];
            end
        end
`ifdef ACLK_KEY_GHOST_REJECT_EN
        if (n > 1) found = NO_KEY;
`endif
        return found;
    endfunction

    function automatic logic [2:0] col_exp(input int edges);
        case ((edges / SCAN_DIV) % 3)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic model_reset();
        key_m     = NO_KEY;
        run_digit = NO_KEY;
        run_len   = 0;
        miss      = 0;
    endtask

    // One frame with a fixed switch pattern; entered just after a frame boundary.
    task automatic run_frame(input logic [11:0] pat, input string tag);
        int res;
        int pulses;
        int exp_pulse;
        pulses    = 0;
        exp_pulse = 0;
        held      = pat;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk);
            #1;
            if (key_pulse) pulses++;
            check({tag, "_col"}, {29'd0, col_n}, {29'd0, col_exp(i)});
        end
        res = frame_result(pat);
        if (key_m == NO_KEY) begin
            if (res == NO_KEY) begin
                run_len = 0;
            end else if (run_len > 0 && res == run_digit) begin
                run_len++;
            end else begin
                run_digit = res;
                run_len   = 1;
            end
            if (run_len >= DF) begin
                key_m     = run_digit;
                exp_pulse = 1;
                miss      = 0;
            end
        end else begin
            if (res == key_m) miss = 0;
            else              miss++;
            if (miss >= DF) begin
                key_m   = NO_KEY;
                run_len = 0;
                miss    = 0;
            end
        end
        check({tag, "_key"}, key, key_m);
        check({tag, "_valid"}, key_valid, (key_m != NO_KEY));
        check({tag, "_pulses"}, pulses, exp_pulse);
    endtask

    task automatic hold(input logic [11:0] pat, input int frames, input string tag);
        for (int f = 0; f < frames; f++) run_frame(pat, tag);
    endtask

    initial begin
        logic [11:0] one;
        logic [11:0] pat;
        int          sel;
        int          frames;
        one = 12'd1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_key", key, NO_KEY);
        check("rst_valid", key_valid, 0);
        check("rst_pulse", key_pulse, 0);
        check("rst_col", col_n, 3'b110);
        @(negedge clk);
        reset = 1'b0;
        check("clk0_col", col_n, 3'b110);

        // Idle scanning, no pulses
        hold('0, 3, "t1_idle");

        // Hold '5' (r1c1, index 4), then release
        hold(12'd1 << 4, 2, "t2_press");
        run_frame(12'd1 << 4, "t2_accept");
        check("t2_key5", key, 5);
        hold(12'd1 << 4, 2, "t2_hold");
        hold('0, 2, "t2_rel");
        check("t2_still5", key, 5);
        run_frame('0, "t2_released");
        check("t2_key10", key, NO_KEY);

        // '7' (index 6) interrupted, then stable
        hold(12'd1 << 6, 2, "t3_pre");
        run_frame('0, "t3_gap");
        hold(12'd1 << 6, 2, "t3_re");
        check("t3_not_yet", key, NO_KEY);
        run_frame(12'd1 << 6, "t3_accept");
        check("t3_key7", key, 7);
        hold('0, 3, "t3_rel");

        // '*' and '#' are ignored
        hold(12'd1 << 9, 10, "t4_star");
        hold(12'd1 << 11, 10, "t4_hash");
        check("t4_key", key, NO_KEY);

        // '1' and '9' together
        hold(12'd1 | (12'd1 << 8), 4, "t5_multi");
`ifdef ACLK_KEY_GHOST_REJECT_EN
        check("t5_key", key, NO_KEY);
`else
        check("t5_key", key, 1);
`endif
        hold('0, 3, "t5_rel");

        // Boundary: key '0' (index 10) and a digit change held straight through release
        hold(12'd1 << 10, 3, "t5b_zero");
        check("t5b_key0", key, 0);
        hold(12'd1 << 1, 7, "t5b_swap");
        check("t5b_key2", key, 2);
        hold('0, 3, "t5b_rel");

        // Reset mid-frame while '3' (index 2) is accepted
        hold(12'd1 << 2, 3, "t6_press");
        check("t6_key3", key, 3);
        held = 12'd1 << 2;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_key", key, NO_KEY);
        check("t6_rst_valid", key_valid, 0);
        check("t6_rst_col", col_n, 3'b110);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        hold(12'd1 << 2, 3, "t6_reacq");
        check("t6_key3_again", key, 3);
        hold('0, 3, "t6_rel");

        // Randomized holds
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       pat = '0;
                1, 2:    pat = one << $urandom_range(0, 11);
                3:       pat = (one << $urandom_range(0, 11)) | (one << $urandom_range(0, 11));
                default: pat = 12'($urandom);
            endcase
            frames = int'($urandom_range(1, 4));
            hold(pat, frames, "rnd");
        end
        hold('0, 3, "final_rel");
        check("final_key", key, NO_KEY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
